// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync and active-video
// decode, line/frame strobes, frame counter and a frame-rate divider tick.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int TICK_DIV = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PIX_EN,
  output logic [CW-1:0] HCOUNT,
  output logic [CW-1:0] VCOUNT,
  output logic          ACTIVE,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic          FRAME_TICK,
  output logic [15:0]   FRAME_CNT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TDW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [TDW-1:0] TICK_LAST = TDW'(TICK_DIV - 1);

  generate
    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (TICK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: TICK_DIV must be >= 1");
    end
  endgenerate

  logic [CW-1:0]  hcount_reg, vcount_reg;
  logic [CW-1:0]  hcount_next, vcount_next;
  logic           active_reg, hsync_reg, vsync_reg;
  logic           line_start_reg, frame_start_reg, frame_tick_reg;
  logic [15:0]    frame_cnt_reg;
  logic [TDW-1:0] tick_div_reg;
  logic           h_wrap, v_wrap, frame_wrap, tick_wrap;

  always_comb begin
    h_wrap      = (hcount_reg == H_LAST);
    v_wrap      = (vcount_reg == V_LAST);
    frame_wrap  = h_wrap && v_wrap;
    tick_wrap   = (tick_div_reg == TICK_LAST);
    hcount_next = h_wrap ? '0 : hcount_reg + 1'b1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = v_wrap ? '0 : vcount_reg + 1'b1;
    end
  end

  // Levels are decoded from the next counts so they register alongside them (zero skew).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      active_reg      <= 1'b1;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_tick_reg  <= 1'b0;
      frame_cnt_reg   <= '0;
      tick_div_reg    <= '0;
    end else if (PIX_EN) begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      active_reg      <= (hcount_next < H_ACT_C) && (vcount_next < V_ACT_C);
      hsync_reg       <= (hcount_next >= HS_FIRST && hcount_next <= HS_LAST) ? HS_POL : ~HS_POL;
      vsync_reg       <= (vcount_next >= VS_FIRST && vcount_next <= VS_LAST) ? VS_POL : ~VS_POL;
      line_start_reg  <= h_wrap;
      frame_start_reg <= frame_wrap;
      frame_tick_reg  <= frame_wrap && tick_wrap;
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
        tick_div_reg  <= tick_wrap ? '0 : tick_div_reg + 1'b1;
      end
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_tick_reg  <= 1'b0;
    end
  end

  assign HCOUNT      = hcount_reg;
  assign VCOUNT      = vcount_reg;
  assign ACTIVE      = active_reg;
  assign HSYNC       = hsync_reg;
  assign VSYNC       = vsync_reg;
  assign LINE_START  = line_start_reg;
  assign FRAME_START = frame_start_reg;
  assign FRAME_TICK  = frame_tick_reg;
  assign FRAME_CNT   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance and two tiny-raster instances,
// checked each cycle against an arithmetic raster model plus directed literal checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  hcount_a, vcount_a, hcount_b, vcount_b, hcount_c, vcount_c;
  logic        active_a, hsync_a, vsync_a, line_start_a, frame_start_a, frame_tick_a;
  logic        active_b, hsync_b, vsync_b, line_start_b, frame_start_b, frame_tick_b;
  logic        active_c, hsync_c, vsync_c, line_start_c, frame_start_c, frame_tick_c;
  logic [15:0] frame_cnt_a, frame_cnt_b, frame_cnt_c;

  vga_timing_gen dut_a (
    .CLK(clk), .RESET(reset), .PIX_EN(pix_en),
    .HCOUNT(hcount_a), .VCOUNT(vcount_a), .ACTIVE(active_a),
    .HSYNC(hsync_a), .VSYNC(vsync_a), .LINE_START(line_start_a),
    .FRAME_START(frame_start_a), .FRAME_TICK(frame_tick_a), .FRAME_CNT(frame_cnt_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .TICK_DIV(4)
  ) dut_b (
    .CLK(clk), .RESET(reset), .PIX_EN(pix_en),
    .HCOUNT(hcount_b), .VCOUNT(vcount_b), .ACTIVE(active_b),
    .HSYNC(hsync_b), .VSYNC(vsync_b), .LINE_START(line_start_b),
    .FRAME_START(frame_start_b), .FRAME_TICK(frame_tick_b), .FRAME_CNT(frame_cnt_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .TICK_DIV(1)
  ) dut_c (
    .CLK(clk), .RESET(reset), .PIX_EN(pix_en),
    .HCOUNT(hcount_c), .VCOUNT(vcount_c), .ACTIVE(active_c),
    .HSYNC(hsync_c), .VSYNC(vsync_c), .LINE_START(line_start_c),
    .FRAME_START(frame_start_c), .FRAME_TICK(frame_tick_c), .FRAME_CNT(frame_cnt_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int hc; int vc; int ac; int hs; int vs; int ls; int fs; int ft; int fc;
  } exp_t;

  // Raster position is pure arithmetic on the number of enabled edges since reset.
  function automatic exp_t model(input longint n, input bit en,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp, input int td);
    exp_t e;
    longint ht, vt, h, v, fr;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    fr = n / (ht * vt);
    e.hc = int'(h);
    e.vc = int'(v);
    e.ac = (h < ha && v < va) ? 1 : 0;
    e.hs = (h >= ha + hf && h < ha + hf + hsw) ? int'(hp) : int'(!hp);
    e.vs = (v >= va + vf && v < va + vf + vsw) ? int'(vp) : int'(!vp);
    e.ls = (en && h == 0) ? 1 : 0;
    e.fs = (en && h == 0 && v == 0) ? 1 : 0;
    e.ft = (e.fs == 1 && (fr % td) == 0) ? 1 : 0;
    e.fc = int'(fr % 65536);
    return e;
  endfunction

  task automatic cmp_dut(input string tag, input exp_t e, input int hc, input int vc,
                         input bit ac, input bit hs, input bit vs, input bit ls,
                         input bit fs, input bit ft, input int fc);
    chk({tag, ".hcount"}, hc, e.hc);
    chk({tag, ".vcount"}, vc, e.vc);
    chk({tag, ".active"}, ac, e.ac);
    chk({tag, ".hsync"}, hs, e.hs);
    chk({tag, ".vsync"}, vs, e.vs);
    chk({tag, ".line_start"}, ls, e.ls);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".frame_tick"}, ft, e.ft);
    chk({tag, ".frame_cnt"}, fc, e.fc);
  endtask

  longint n_edges = 0;
  bit     last_en = 1'b0;
  bit     checking = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n_edges <= 0;
      last_en <= 1'b0;
    end else begin
      if (pix_en) n_edges <= n_edges + 1;
      last_en <= pix_en;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp_dut("a", model(n_edges, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16),
              int'(hcount_a), int'(vcount_a), active_a, hsync_a, vsync_a,
              line_start_a, frame_start_a, frame_tick_a, int'(frame_cnt_a));
      cmp_dut("b", model(n_edges, last_en, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 4),
              int'(hcount_b), int'(vcount_b), active_b, hsync_b, vsync_b,
              line_start_b, frame_start_b, frame_tick_b, int'(frame_cnt_b));
      cmp_dut("c", model(n_edges, last_en, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1),
              int'(hcount_c), int'(vcount_c), active_c, hsync_c, vsync_c,
              line_start_c, frame_start_c, frame_tick_c, int'(frame_cnt_c));
    end
  end

  initial begin
    int hs_low, last_ls, ticks_b, ticks_c, k;

    reset = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    chk("rst_hcount_a", hcount_a, 0);
    chk("rst_vcount_a", vcount_a, 0);
    chk("rst_active_a", active_a, 1);
    chk("rst_hsync_a", hsync_a, 1);
    chk("rst_vsync_a", vsync_a, 1);
    chk("rst_line_start_a", line_start_a, 0);
    chk("rst_frame_cnt_a", frame_cnt_a, 0);
    chk("rst_hsync_b", hsync_b, 0);
    chk("rst_vsync_b", vsync_b, 0);
    $display("txn reset: a=(%0d,%0d) hs=%0b vs=%0b", hcount_a, vcount_a, hsync_a, vsync_a);
    reset = 1'b0;

    // Continuous pixel enable: line timing on dut_a, frame/tick behaviour on the tiny rasters.
    pix_en = 1'b1;
    hs_low = 0; last_ls = -1; ticks_b = 0; ticks_c = 0;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      if (i < 800 && hsync_a == 1'b0) hs_low++;
      if (i == 799) chk("hsync_low_cycles", hs_low, 96);
      if (i == 655) begin
        chk("h656_hcount", hcount_a, 656);
        chk("h656_hsync", hsync_a, 0);
      end
      if (line_start_a) begin
        if (last_ls >= 0) chk("ls_period_cont", i - last_ls, 800);
        last_ls = i;
        $display("txn line_start a at cycle %0d vcount=%0d", i, vcount_a);
      end
      if (i == 36) begin
        chk("b_h5v4_hsync", hsync_b, 1);
        chk("b_h5v4_vsync", vsync_b, 1);
        chk("b_h5v4_pos", {hcount_b, vcount_b}, {10'd5, 10'd4});
      end
      if (i == 46) chk("b_pre_wrap_pos", {hcount_b, vcount_b}, {10'd7, 10'd5});
      if (i == 47) begin
        chk("b_wrap_pos", {hcount_b, vcount_b}, 0);
        chk("b_wrap_frame_start", frame_start_b, 1);
        chk("b_wrap_line_start", line_start_b, 1);
      end
      if (i < 432) begin
        if (frame_tick_b) begin
          ticks_b++;
          chk("b_tick_frame", frame_cnt_b, ticks_b * 4);
          $display("txn frame_tick b at frame %0d", frame_cnt_b);
        end
        if (frame_tick_c) ticks_c++;
      end
      if (i == 431) begin
        chk("b_frame_cnt_9", frame_cnt_b, 9);
        chk("b_tick_count", ticks_b, 2);
        chk("c_tick_count", ticks_c, 9);
      end
    end

    // Half-rate enable: every period doubles.
    last_ls = -1;
    for (int i = 0; i < 3400; i++) begin
      pix_en = (i % 2 == 0);
      @(posedge clk);
      #1;
      if (line_start_a) begin
        if (last_ls >= 0) chk("ls_period_toggle", i - last_ls, 1600);
        last_ls = i;
        $display("txn line_start a (toggled) at cycle %0d vcount=%0d", i, vcount_a);
      end
    end

    // Mid-frame reset at HCOUNT=300.
    pix_en = 1'b1;
    k = 0;
    while (k < 1000 && hcount_a != 10'd300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_h300", hcount_a, 300);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pos", {hcount_a, vcount_a}, 0);
    chk("midrst_hsync", hsync_a, 1);
    chk("midrst_vsync", vsync_a, 1);
    chk("midrst_active", active_a, 1);
    chk("midrst_frame_cnt_b", frame_cnt_b, 0);
    chk("midrst_strobes", {line_start_a, frame_start_a, line_start_b, frame_start_b}, 0);
    $display("txn mid-frame reset: a=(%0d,%0d)", hcount_a, vcount_a);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_hcount", hcount_a, 1);
    chk("post_rst_no_strobe", {line_start_a, frame_start_a}, 0);
    repeat (10) @(posedge clk);
    #1;
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
